// File: rtl/force_ring_injector_pkg.sv
// Shared types for the force output ring.
// Contents: particle/cell widths, float_data_t, force_packet_t, cell_offset_t,
//   injector FSM state type and wrap_coord(), the periodic-boundary coordinate helper
//   also used by the position ring.
package force_ring_injector_pkg;

    localparam int unsigned PARTICLE_ID_WIDTH = 8;
    localparam int unsigned CELL_COORD_WIDTH  = 2;
    localparam int unsigned NUM_CELLS         = 27;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } float_data_t;

    typedef logic [3*CELL_COORD_WIDTH-1:0] cell_id_t;

    typedef struct packed {
        float_data_t                  f;
        cell_id_t                     cid;
        logic [PARTICLE_ID_WIDTH-1:0] parid;
    } force_packet_t;

    // Per-axis 2b two's complement: 00=0, 01=+1, 11=-1, 10=illegal.
    typedef struct packed {
        logic [CELL_COORD_WIDTH-1:0] dx;
        logic [CELL_COORD_WIDTH-1:0] dy;
        logic [CELL_COORD_WIDTH-1:0] dz;
    } cell_offset_t;

    typedef enum logic [1:0] {
        StDone  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } inj_state_e;

    // 1-based coordinate plus a -1/0/+1 step, wrapped periodically over 1..cell_dim.
    function automatic logic [CELL_COORD_WIDTH-1:0] wrap_coord(
        input logic [CELL_COORD_WIDTH-1:0] coord,
        input logic [CELL_COORD_WIDTH-1:0] delta,
        input int                          cell_dim
    );
        int c;
        c = int'(coord) + int'($signed(delta));
        if (c == 0) begin
            c = cell_dim;
        end else if (c == cell_dim + 1) begin
            c = 1;
        end
        return c[CELL_COORD_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/force_ring_inj_fifo.sv
// Synchronous first-word-fall-through FIFO of force_packet_t.
// Ports:
//   clk, rst (async active-low)
//   push, wdata        write one entry
//   pop                consume the head entry
//   rdata              head entry, valid whenever count != 0
//   count              occupancy, 0..DEPTH
// The caller never pushes when full nor pops when empty.
module force_ring_inj_fifo
    import force_ring_injector_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  force_packet_t            wdata,
    input  logic                     pop,
    output force_packet_t            rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    force_packet_t           mem [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]           count_q;

    // Storage carries no reset; only pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/force_ring_injector.sv
// Transmit end of the force output ring, one per cell.
// Resolves each neighbour force's relative cell offset into an absolute destination cid,
// buffers the packets and injects them into the ring under backpressure. A RUN/DRAIN/DONE
// FSM tells the controller when every accepted force has left the cell.
// Ports:
//   clk, rst                 clock, async active-low reset
//   i_home_cid               this cell {x,y,z}, static after reset
//   i_frc/_parid/_offset     neighbour force beat; i_frc_valid / o_frc_ready handshake
//   i_ring_ready             ring accepts o_nb_force this cycle
//   o_nb_force(_valid)       packet to ring, held stable while stalled
//   i_start, i_flush         timestep begin / evaluator finished
//   o_done                   high only in DONE (including straight out of reset)
//   o_err_offset             sticky illegal-offset flag, cleared by reset or i_start
// Build option: define FORCE_RING_INJ_STATS_EN to add saturating o_stat_sent,
//   o_stat_dropped and o_stat_stall counters (cleared on reset and i_start).
module force_ring_injector
    import force_ring_injector_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CELL_DIM   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [5:0]                   i_home_cid,
    input  float_data_t                  i_frc,
    input  logic [PARTICLE_ID_WIDTH-1:0] i_frc_parid,
    input  logic [5:0]                   i_frc_offset,
    input  logic                         i_frc_valid,
    output logic                         o_frc_ready,
    input  logic                         i_ring_ready,
    output force_packet_t                o_nb_force,
    output logic                         o_nb_force_valid,
    input  logic                         i_start,
    input  logic                         i_flush,
    output logic                         o_done,
    output logic                         o_err_offset
`ifdef FORCE_RING_INJ_STATS_EN
    ,
    output logic [15:0]                  o_stat_sent,
    output logic [15:0]                  o_stat_dropped,
    output logic [15:0]                  o_stat_stall
`endif
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    inj_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic            s1_valid_q, s1_valid_d;
    force_packet_t   s1_pkt_q, s1_pkt_d;
    logic            out_valid_q, out_valid_d;
    force_packet_t   out_pkt_q, out_pkt_d;
    logic            err_q, err_d;

    logic            accept, start_acc;
    cell_offset_t    off;
    logic            off_illegal, off_home;
    logic            out_free, fifo_empty, bypass, push, pop;
    logic [CntW-1:0] fifo_count, count_next;
    force_packet_t   fifo_head;

    force_ring_inj_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (s1_pkt_q),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    always_comb begin
        accept      = i_frc_valid && ready_q;
        start_acc   = i_start && (state_q == StDone);
        off         = cell_offset_t'(i_frc_offset);
        off_illegal = (off.dx == 2'b10) || (off.dy == 2'b10) || (off.dz == 2'b10);
        off_home    = (off == '0);

        // Stage 1: resolve destination cid; home and illegal offsets never reach the buffer.
        s1_valid_d = accept && !off_illegal && !off_home;
        s1_pkt_d   = s1_pkt_q;
        if (accept) begin
            s1_pkt_d.f     = i_frc;
            s1_pkt_d.parid = i_frc_parid;
            s1_pkt_d.cid   = {wrap_coord(i_home_cid[5:4], off.dx, int'(CELL_DIM)),
                              wrap_coord(i_home_cid[3:2], off.dy, int'(CELL_DIM)),
                              wrap_coord(i_home_cid[1:0], off.dz, int'(CELL_DIM))};
        end

        // Stage 2: the out reg takes the FIFO head, or stage 1 directly when the FIFO is
        // empty. The bypass gives two-cycle latency without breaking order.
        fifo_empty  = (fifo_count == '0);
        out_free    = !out_valid_q || i_ring_ready;
        pop         = out_free && !fifo_empty;
        bypass      = out_free && fifo_empty && s1_valid_q;
        push        = s1_valid_q && !bypass;
        out_valid_d = out_valid_q;
        out_pkt_d   = out_pkt_q;
        if (out_free) begin
            out_valid_d = !fifo_empty || s1_valid_q;
            if (!fifo_empty) begin
                out_pkt_d = fifo_head;
            end else if (s1_valid_q) begin
                out_pkt_d = s1_pkt_q;
            end
        end

        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            StDone:  if (i_start) state_d = StRun;
            StRun:   if (i_flush) state_d = StDrain;
            StDrain: begin
                // Everything empties at this edge: stage 1, FIFO and the out reg.
                if (!accept && !s1_valid_q && fifo_empty && out_free) begin
                    state_d = StDone;
                end
            end
            default: state_d = StDone;
        endcase

        // Registered ready, computed from next-state values so it never depends
        // combinationally on i_ring_ready at the output.
        ready_d = (state_d != StDone) &&
                  ((32'(count_next) + 32'(s1_valid_d)) < FIFO_DEPTH);

        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (accept && off_illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StDone;
            ready_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_pkt_q    <= '0;
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_pkt_q    <= s1_pkt_d;
            out_valid_q <= out_valid_d;
            out_pkt_q   <= out_pkt_d;
            err_q       <= err_d;
        end
    end

    assign o_frc_ready      = ready_q;
    assign o_nb_force       = out_pkt_q;
    assign o_nb_force_valid = out_valid_q;
    assign o_done           = (state_q == StDone);
    assign o_err_offset     = err_q;

`ifdef FORCE_RING_INJ_STATS_EN
    logic [15:0] sent_q, dropped_q, stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_q    <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else if (start_acc) begin
            sent_q    <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else begin
            if (out_valid_q && i_ring_ready && (sent_q != 16'hFFFF)) begin
                sent_q <= sent_q + 16'd1;
            end
            if (accept && (off_illegal || off_home) && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
            if (out_valid_q && !i_ring_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign o_stat_sent    = sent_q;
    assign o_stat_dropped = dropped_q;
    assign o_stat_stall   = stall_q;
`endif

endmodule

// File: tb/tb_force_ring_injector.sv
// Directed self-checking bench for force_ring_injector.
module tb_force_ring_injector;
    import force_ring_injector_pkg::*;

    logic                         clk;
    logic                         rst;
    logic [5:0]                   i_home_cid;
    float_data_t                  i_frc;
    logic [PARTICLE_ID_WIDTH-1:0] i_frc_parid;
    logic [5:0]                   i_frc_offset;
    logic                         i_frc_valid;
    logic                         o_frc_ready;
    logic                         i_ring_ready;
    force_packet_t                o_nb_force;
    logic                         o_nb_force_valid;
    logic                         i_start;
    logic                         i_flush;
    logic                         o_done;
    logic                         o_err_offset;
`ifdef FORCE_RING_INJ_STATS_EN
    logic [15:0]                  o_stat_sent, o_stat_dropped, o_stat_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    force_packet_t rx_q[$];

    force_ring_injector #(
        .FIFO_DEPTH (16),
        .CELL_DIM   (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_home_cid       (i_home_cid),
        .i_frc            (i_frc),
        .i_frc_parid      (i_frc_parid),
        .i_frc_offset     (i_frc_offset),
        .i_frc_valid      (i_frc_valid),
        .o_frc_ready      (o_frc_ready),
        .i_ring_ready     (i_ring_ready),
        .o_nb_force       (o_nb_force),
        .o_nb_force_valid (o_nb_force_valid),
        .i_start          (i_start),
        .i_flush          (i_flush),
        .o_done           (o_done),
        .o_err_offset     (o_err_offset)
`ifdef FORCE_RING_INJ_STATS_EN
        ,
        .o_stat_sent      (o_stat_sent),
        .o_stat_dropped   (o_stat_dropped),
        .o_stat_stall     (o_stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring model: record every handshake.
    always @(posedge clk) begin
        if (rst && o_nb_force_valid && i_ring_ready) begin
            rx_q.push_back(o_nb_force);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [5:0] home);
        rst          = 1'b0;
        i_home_cid   = home;
        i_frc        = '0;
        i_frc_parid  = '0;
        i_frc_offset = '0;
        i_frc_valid  = 1'b0;
        i_ring_ready = 1'b1;
        i_start      = 1'b0;
        i_flush      = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rx_q.delete();
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    // Present one beat and hold it until accepted; returns #1 after the accept edge.
    task automatic send_beat(input logic [5:0] off, input logic [7:0] pid);
        int n;
        n            = 0;
        i_frc_valid  = 1'b1;
        i_frc_offset = off;
        i_frc_parid  = pid;
        i_frc.x      = 32'h3F80_0000;
        i_frc.y      = 32'h4000_0000 + 32'(pid);
        i_frc.z      = 32'hBF80_0000;
        while (!o_frc_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!o_frc_ready) check("send_timeout", 64'(o_frc_ready), 64'd1);
        tick(1);
        i_frc_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int hs;
        logic hit;

        // 1: reset state, then cid resolution and two-cycle latency.
        do_reset(6'b101010);
        check("rst_valid", 64'(o_nb_force_valid), 64'd0);
        check("rst_ready", 64'(o_frc_ready), 64'd0);
        check("rst_done", 64'(o_done), 64'd1);
        check("rst_err", 64'(o_err_offset), 64'd0);
        pulse_start();
        check("run_ready", 64'(o_frc_ready), 64'd1);
        check("run_done", 64'(o_done), 64'd0);
        i_frc_valid  = 1'b1;
        i_frc_offset = 6'b010011;
        i_frc_parid  = 8'd5;
        i_frc.x      = 32'h3F80_0000;
        i_frc.y      = 32'h0;
        i_frc.z      = 32'h0;
        tick(1);
        i_frc_valid = 1'b0;
        check("t1_n1_valid", 64'(o_nb_force_valid), 64'd0);
        tick(1);
        check("t1_n2_valid", 64'(o_nb_force_valid), 64'd1);
        check("t1_cid", 64'(o_nb_force.cid), 64'b111001);
        check("t1_parid", 64'(o_nb_force.parid), 64'd5);
        check("t1_fx", 64'(o_nb_force.f.x), 64'h3F80_0000);
        tick(1);
        check("t1_one_beat", 64'(o_nb_force_valid), 64'd0);
        check("t1_rx_count", 64'(rx_q.size()), 64'd1);

        // 2: wrap in both directions.
        do_reset(6'b111111);
        pulse_start();
        send_beat(6'b010101, 8'd7);
        tick(4);
        check("t2a_count", 64'(rx_q.size()), 64'd1);
        if (rx_q.size() > 0) check("t2a_cid", 64'(rx_q[0].cid), 64'b010101);
        do_reset(6'b010101);
        pulse_start();
        send_beat(6'b111111, 8'd8);
        tick(4);
        check("t2b_count", 64'(rx_q.size()), 64'd1);
        if (rx_q.size() > 0) check("t2b_cid", 64'(rx_q[0].cid), 64'b111111);

        // 3: home and illegal offsets are dropped; only the illegal one flags.
        do_reset(6'b101010);
        pulse_start();
        send_beat(6'b000000, 8'd1);
        check("t3_err_home", 64'(o_err_offset), 64'd0);
        tick(3);
        send_beat(6'b100000, 8'd2);
        check("t3_err_illegal", 64'(o_err_offset), 64'd1);
        tick(4);
        check("t3_nothing_sent", 64'(rx_q.size()), 64'd0);
        check("t3_err_sticky", 64'(o_err_offset), 64'd1);
`ifdef FORCE_RING_INJ_STATS_EN
        check("t3_stat_dropped", 64'(o_stat_dropped), 64'd2);
`endif
        pulse_start(); // ignored in RUN, flag stays
        check("t3_start_in_run", 64'(o_err_offset), 64'd1);

        // 4: ring stalled, offer 20 beats: 17 accepted, delivered in order on release.
        do_reset(6'b101010);
        i_ring_ready = 1'b0;
        pulse_start();
        acc          = 0;
        i_frc_valid  = 1'b1;
        i_frc_offset = 6'b010011;
        for (int c = 0; c < 40 && acc < 20; c++) begin
            i_frc_parid = 8'(acc);
            hit         = o_frc_ready;
            tick(1);
            if (hit) acc++;
        end
        i_frc_valid = 1'b0;
        check("t4_accepted", 64'(acc), 64'd17);
        check("t4_ready_low", 64'(o_frc_ready), 64'd0);
        check("t4_hold_valid", 64'(o_nb_force_valid), 64'd1);
        check("t4_hold_parid", 64'(o_nb_force.parid), 64'd0);
        check("t4_hold_cid", 64'(o_nb_force.cid), 64'b111001);
        i_ring_ready = 1'b1;
        tick(25);
        check("t4_rx_count", 64'(rx_q.size()), 64'd17);
        for (int i = 0; i < rx_q.size(); i++) begin
            check($sformatf("t4_order%0d", i), 64'(rx_q[i].parid), 64'(i));
        end
        check("t4_ready_back", 64'(o_frc_ready), 64'd1);

        // 5: done tracks the last handshake during drain.
        do_reset(6'b101010);
        i_ring_ready = 1'b0;
        pulse_start();
        send_beat(6'b010011, 8'd10);
        send_beat(6'b000001, 8'd11);
        send_beat(6'b110000, 8'd12);
        i_flush = 1'b1;
        tick(1);
        i_flush = 1'b0;
        tick(5);
        check("t5_done_stalled", 64'(o_done), 64'd0);
        i_ring_ready = 1'b1;
        hs           = 0;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            if (o_nb_force_valid) hs++;
            if (hs < 3) check($sformatf("t5_done_low%0d", c), 64'(o_done), 64'd0);
            tick(1);
        end
        check("t5_hs", 64'(hs), 64'd3);
        check("t5_done_high", 64'(o_done), 64'd1);
        check("t5_ready_done", 64'(o_frc_ready), 64'd0);

        // 6: async reset discards buffered packets.
        do_reset(6'b101010);
        i_ring_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_beat(6'b010011, 8'(20 + i));
        tick(2);
        check("t6_valid_before", 64'(o_nb_force_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_valid_async", 64'(o_nb_force_valid), 64'd0);
        tick(1);
        rst = 1'b1;
        tick(2);
        check("t6_done", 64'(o_done), 64'd1);
        check("t6_ready_idle", 64'(o_frc_ready), 64'd0);
        rx_q.delete();
        i_ring_ready = 1'b1;
        pulse_start();
        check("t6_ready_run", 64'(o_frc_ready), 64'd1);
        tick(5);
        check("t6_discarded", 64'(rx_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
